// File: rtl/ltc_decoder.sv
// SMPTE LTC biphase-mark decoder: recovers the 80-bit frame, publishes BCD time fields.
// Optional frame parity check is built only when LTC_PARITY_EN is defined.
module ltc_decoder #(
  parameter int MIN_PULSE = 1000,
  parameter int THRESH    = 4000,
  parameter int TIMEOUT   = 8000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ltc_in,
  output logic [3:0] frm_u,
  output logic [1:0] frm_d,
  output logic [3:0] sec_u,
  output logic [2:0] sec_d,
  output logic [3:0] min_u,
  output logic [2:0] min_d,
  output logic [3:0] hrs_u,
  output logic [1:0] hrs_d,
  output logic       drop_frame,
  output logic       color_frame,
  output logic       frame_valid,
  output logic       locked,
  output logic       parity_err
);

  localparam logic [0:0]  ST_HUNT     = 1'b0;
  localparam logic [0:0]  ST_SYNCED   = 1'b1;
  localparam logic [12:0] MIN_CNT     = 13'(MIN_PULSE);
  localparam logic [12:0] THRESH_CNT  = 13'(THRESH);
  localparam logic [12:0] TIMEOUT_CNT = 13'(TIMEOUT);
  localparam logic [15:0] SYNC_WORD   = 16'h3FFD;
  localparam logic [6:0]  FRAME_BITS  = 7'd80;
  localparam logic [6:0]  BITS_MAX    = 7'd127;

  logic        sync1, sync2, sync3, edge_q;
  logic [12:0] interval;
  logic        half_pending;
  logic [79:0] sr;
  logic        shift_q;
  logic [6:0]  bits_since;
  logic [0:0]  state;

  logic is_glitch, is_full, timeout_hit, decode_err;
  logic bit_valid, bit_val, sync_match, good_frame, load_frame;
  logic parity_odd;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync1  <= ltc_in;
      sync2  <= sync1;
      sync3  <= sync2;
      edge_q <= sync2 ^ sync3;
    end
  end

  always_comb begin
    // NOTE: every combinational output is assigned unconditionally so no latch is inferred.
    is_glitch   = interval < MIN_CNT;
    is_full     = interval >= THRESH_CNT;
    timeout_hit = !edge_q && (interval == TIMEOUT_CNT);
    decode_err  = (edge_q && (is_glitch || (is_full && half_pending))) || timeout_hit;
    // A full cell is shifted even on a framing error so a sync word right after it is not lost.
    bit_valid   = edge_q && !is_glitch && (is_full || half_pending);
    bit_val     = !is_full;
    sync_match  = shift_q && (sr[15:0] == SYNC_WORD);
    good_frame  = !decode_err && (state == ST_SYNCED) && sync_match &&
                  (bits_since == FRAME_BITS);
    load_frame  = good_frame && !parity_odd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      interval <= '0;
    end else if (edge_q) begin
      interval <= '0;
    end else if (interval != TIMEOUT_CNT) begin
      interval <= interval + 13'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_pending <= 1'b0;
      sr           <= '0;
      shift_q      <= 1'b0;
    end else begin
      shift_q <= bit_valid;
      if (bit_valid) begin
        sr <= {sr[78:0], bit_val};
      end
      if (decode_err) begin
        half_pending <= 1'b0;
      end else if (edge_q && !is_full) begin
        half_pending <= !half_pending;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_HUNT;
      bits_since  <= '0;
      locked      <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (bit_valid && (bits_since != BITS_MAX)) begin
        bits_since <= bits_since + 7'd1;
      end
      if (decode_err) begin
        state  <= ST_HUNT;
        locked <= 1'b0;
      end else if (state == ST_HUNT) begin
        if (sync_match) begin
          bits_since <= '0;
          state      <= ST_SYNCED;
        end
      end else if (sync_match) begin
        bits_since <= '0;
        if (bits_since != FRAME_BITS) begin
          state  <= ST_HUNT;
          locked <= 1'b0;
        end else if (load_frame) begin
          locked      <= 1'b1;
          frame_valid <= 1'b1;
        end
      end else if (bits_since > FRAME_BITS) begin
        state  <= ST_HUNT;
        locked <= 1'b0;
      end
    end
  end

  // LTC bit k sits at sr[79-k]; each field is reassembled LSB-first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frm_u       <= '0;
      frm_d       <= '0;
      sec_u       <= '0;
      sec_d       <= '0;
      min_u       <= '0;
      min_d       <= '0;
      hrs_u       <= '0;
      hrs_d       <= '0;
      drop_frame  <= 1'b0;
      color_frame <= 1'b0;
    end else if (load_frame) begin
      frm_u       <= {sr[76], sr[77], sr[78], sr[79]};
      frm_d       <= {sr[70], sr[71]};
      drop_frame  <= sr[69];
      color_frame <= sr[68];
      sec_u       <= {sr[60], sr[61], sr[62], sr[63]};
      sec_d       <= {sr[53], sr[54], sr[55]};
      min_u       <= {sr[44], sr[45], sr[46], sr[47]};
      min_d       <= {sr[37], sr[38], sr[39]};
      hrs_u       <= {sr[28], sr[29], sr[30], sr[31]};
      hrs_d       <= {sr[22], sr[23]};
    end
  end

`ifdef LTC_PARITY_EN
  assign parity_odd = ^sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= good_frame && parity_odd;
    end
  end
`else
  assign parity_odd = 1'b0;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ltc_decoder.sv
// Directed bench for ltc_decoder with timing parameters scaled down by 200.
// Define LTC_PARITY_EN for both files to exercise the parity scenario.
module tb_ltc_decoder;

  localparam int MIN_P   = 5;
  localparam int THR     = 20;
  localparam int TMO     = 40;
  localparam int HALF_25 = 15;
  localparam int HALF_24 = 16;
  localparam int HALF_30 = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ltc_in = 1'b0;
  logic [3:0] frm_u, sec_u, min_u, hrs_u;
  logic [1:0] frm_d, hrs_d;
  logic [2:0] sec_d, min_d;
  logic       drop_frame, color_frame, frame_valid, locked, parity_err;

  int          asserts = 0;
  int          failures = 0;
  int          fv_cnt = 0;
  int          pe_cnt = 0;
  logic [27:0] last_fv = '0;

  ltc_decoder #(.MIN_PULSE(MIN_P), .THRESH(THR), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .ltc_in(ltc_in),
    .frm_u(frm_u), .frm_d(frm_d), .sec_u(sec_u), .sec_d(sec_d),
    .min_u(min_u), .min_d(min_d), .hrs_u(hrs_u), .hrs_d(hrs_d),
    .drop_frame(drop_frame), .color_frame(color_frame),
    .frame_valid(frame_valid), .locked(locked), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] cur_fields();
    return {drop_frame, color_frame, hrs_d, hrs_u, min_d, min_u, sec_d, sec_u, frm_d, frm_u};
  endfunction

  function automatic logic [27:0] exp_fields(int h, int m, int s, int f, logic df, logic cf);
    return {df, cf, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10), 2'(f / 10), 4'(f % 10)};
  endfunction

  // Frame indexed by LTC bit number; bit 59 forces an even ones-count.
  function automatic logic [79:0] build_frame(int h, int m, int s, int f, logic df, logic cf);
    logic [79:0] fr;
    fr          = '0;
    fr[3:0]     = 4'(f % 10);
    fr[9:8]     = 2'(f / 10);
    fr[10]      = df;
    fr[11]      = cf;
    fr[19:16]   = 4'(s % 10);
    fr[26:24]   = 3'(s / 10);
    fr[35:32]   = 4'(m % 10);
    fr[42:40]   = 3'(m / 10);
    fr[51:48]   = 4'(h % 10);
    fr[57:56]   = 2'(h / 10);
    fr[79:64]   = 16'hBFFC;
    if (^fr) fr[59] = 1'b1;
    return fr;
  endfunction

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_cnt++;
      last_fv = cur_fields();
    end
    if (parity_err === 1'b1) pe_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int half);
    ltc_in = ~ltc_in;
    wait_cyc(half);
    if (b) ltc_in = ~ltc_in;
    wait_cyc(half);
  endtask

  task automatic send_frame(input logic [79:0] fr, input int half);
    for (int k = 0; k < 80; k++) send_bit(fr[k], half);
  endtask

  task automatic flush();
    ltc_in = ~ltc_in;
    wait_cyc(10);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(50);
  endtask

  task automatic test_reset();
    wait_cyc(3);
    asserts++;
    if (cur_fields() !== 28'h0) begin
      failures++; $display("FAIL reset_fields: got %h expected 0", cur_fields());
    end
    asserts++;
    if ({locked, frame_valid, parity_err} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b expected 000", {locked, frame_valid, parity_err});
    end
    reset = 1'b0;
    wait_cyc(50);
    asserts++;
    if (locked !== 1'b0 || fv_cnt != 0) begin
      failures++; $display("FAIL idle_after_reset: locked %b fv %0d expected 0 0", locked, fv_cnt);
    end
  endtask

  task automatic test_25fps();
    logic [79:0] fr;
    int base;
    apply_reset();
    base = fv_cnt;
    fr = build_frame(12, 34, 56, 17, 1'b0, 1'b0);
    send_frame(fr, HALF_25);
    send_frame(fr, HALF_25);
    asserts++;
    if (fv_cnt - base != 0) begin
      failures++; $display("FAIL 25_early_fv: got %0d strobes expected 0", fv_cnt - base);
    end
    ltc_in = ~ltc_in;
    wait_cyc(4);
    asserts++;
    if (frame_valid !== 1'b0) begin
      failures++; $display("FAIL 25_fv_cycle4: got %b expected 0", frame_valid);
    end
    wait_cyc(1);
    asserts++;
    if (frame_valid !== 1'b1) begin
      failures++; $display("FAIL 25_fv_cycle5: got %b expected 1", frame_valid);
    end
    asserts++;
    if (cur_fields() !== exp_fields(12, 34, 56, 17, 1'b0, 1'b0)) begin
      failures++; $display("FAIL 25_fields: got %h expected %h", cur_fields(), exp_fields(12, 34, 56, 17, 1'b0, 1'b0));
    end
    wait_cyc(5);
    asserts++;
    if (fv_cnt - base != 1 || locked !== 1'b1) begin
      failures++; $display("FAIL 25_count_lock: got %0d/%b expected 1/1", fv_cnt - base, locked);
    end
  endtask

  task automatic test_reset_abort();
    wait_cyc(3);
    asserts++;
    if (locked !== 1'b1) begin
      failures++; $display("FAIL abort_pre_lock: got %b expected 1", locked);
    end
    reset = 1'b1;
    #1;
    asserts++;
    if (locked !== 1'b0 || cur_fields() !== 28'h0) begin
      failures++; $display("FAIL abort_clear: locked %b fields %h expected 0 0", locked, cur_fields());
    end
    wait_cyc(2);
  endtask

  task automatic test_24fps();
    logic [79:0] fr;
    int base;
    apply_reset();
    base = fv_cnt;
    fr = build_frame(23, 59, 59, 23, 1'b0, 1'b0);
    send_frame(fr, HALF_24);
    send_frame(fr, HALF_24);
    flush();
    asserts++;
    if (fv_cnt - base != 1) begin
      failures++; $display("FAIL 24_count: got %0d expected 1", fv_cnt - base);
    end
    asserts++;
    if (last_fv !== exp_fields(23, 59, 59, 23, 1'b0, 1'b0)) begin
      failures++; $display("FAIL 24_fields: got %h expected %h", last_fv, exp_fields(23, 59, 59, 23, 1'b0, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    int base;
    apply_reset();
    base = fv_cnt;
    send_frame(build_frame(0, 0, 0, 28, 1'b0, 1'b0), HALF_30);
    send_frame(build_frame(0, 0, 0, 29, 1'b1, 1'b0), HALF_30);
    send_frame(build_frame(0, 0, 1, 0, 1'b0, 1'b1), HALF_30);
    asserts++;
    if (fv_cnt - base != 1 || last_fv !== exp_fields(0, 0, 0, 29, 1'b1, 1'b0)) begin
      failures++; $display("FAIL 30_first: got %0d/%h expected 1/%h", fv_cnt - base, last_fv, exp_fields(0, 0, 0, 29, 1'b1, 1'b0));
    end
    flush();
    asserts++;
    if (fv_cnt - base != 2 || last_fv !== exp_fields(0, 0, 1, 0, 1'b0, 1'b1)) begin
      failures++; $display("FAIL 30_second: got %0d/%h expected 2/%h", fv_cnt - base, last_fv, exp_fields(0, 0, 1, 0, 1'b0, 1'b1));
    end
    asserts++;
    if (locked !== 1'b1) begin
      failures++; $display("FAIL 30_lock: got %b expected 1", locked);
    end
  endtask

  task automatic test_glitch();
    logic [79:0] fr;
    int base;
    apply_reset();
    base = fv_cnt;
    send_frame(build_frame(1, 2, 3, 4, 1'b0, 1'b0), HALF_25);
    send_frame(build_frame(1, 2, 3, 5, 1'b0, 1'b0), HALF_25);
    fr = build_frame(1, 2, 3, 6, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_bit(fr[k], HALF_25);
    asserts++;
    if (locked !== 1'b1) begin
      failures++; $display("FAIL glitch_pre_lock: got %b expected 1", locked);
    end
    // Bit 4 is a '0' cell carrying a 2-cycle pulse two cycles into it.
    ltc_in = ~ltc_in;
    wait_cyc(2);
    ltc_in = ~ltc_in;
    wait_cyc(2);
    ltc_in = ~ltc_in;
    wait_cyc(2);
    asserts++;
    if (locked !== 1'b0) begin
      failures++; $display("FAIL glitch_lock_drop: got %b expected 0", locked);
    end
    wait_cyc(2 * HALF_25 - 6);
    for (int k = 5; k < 80; k++) send_bit(fr[k], HALF_25);
    send_frame(build_frame(1, 2, 3, 7, 1'b0, 1'b0), HALF_25);
    asserts++;
    if (fv_cnt - base != 1 || last_fv !== exp_fields(1, 2, 3, 5, 1'b0, 1'b0)) begin
      failures++; $display("FAIL glitch_no_fv: got %0d/%h expected 1/%h", fv_cnt - base, last_fv, exp_fields(1, 2, 3, 5, 1'b0, 1'b0));
    end
    flush();
    asserts++;
    if (fv_cnt - base != 2 || locked !== 1'b1 || last_fv !== exp_fields(1, 2, 3, 7, 1'b0, 1'b0)) begin
      failures++; $display("FAIL glitch_relock: got %0d/%b/%h expected 2/1/%h", fv_cnt - base, locked, last_fv, exp_fields(1, 2, 3, 7, 1'b0, 1'b0));
    end
  endtask

  task automatic test_timeout();
    int base;
    base = fv_cnt;
    ltc_in = ~ltc_in;
    wait_cyc(44);
    asserts++;
    if (locked !== 1'b1) begin
      failures++; $display("FAIL timeout_early: got %b expected 1", locked);
    end
    wait_cyc(1);
    asserts++;
    if (locked !== 1'b0) begin
      failures++; $display("FAIL timeout_drop: got %b expected 0", locked);
    end
    wait_cyc(5);
    asserts++;
    if (cur_fields() !== exp_fields(1, 2, 3, 7, 1'b0, 1'b0) || fv_cnt != base) begin
      failures++; $display("FAIL timeout_hold: got %h/%0d expected %h/%0d", cur_fields(), fv_cnt, exp_fields(1, 2, 3, 7, 1'b0, 1'b0), base);
    end
  endtask

  task automatic test_bit_slip();
    int base;
    apply_reset();
    base = fv_cnt;
    send_frame(build_frame(10, 20, 30, 0, 1'b0, 1'b0), HALF_25);
    send_frame(build_frame(10, 20, 30, 1, 1'b0, 1'b0), HALF_25);
    send_bit(1'b0, HALF_25);
    send_frame(build_frame(10, 20, 30, 2, 1'b0, 1'b0), HALF_25);
    asserts++;
    if (fv_cnt - base != 1 || locked !== 1'b1) begin
      failures++; $display("FAIL slip_pre: got %0d/%b expected 1/1", fv_cnt - base, locked);
    end
    send_frame(build_frame(10, 20, 30, 3, 1'b0, 1'b0), HALF_25);
    asserts++;
    if (fv_cnt - base != 1 || locked !== 1'b0) begin
      failures++; $display("FAIL slip_81: got %0d/%b expected 1/0", fv_cnt - base, locked);
    end
    flush();
    asserts++;
    if (fv_cnt - base != 1 || locked !== 1'b0 || last_fv !== exp_fields(10, 20, 30, 1, 1'b0, 1'b0)) begin
      failures++; $display("FAIL slip_hunt: got %0d/%b/%h expected 1/0/%h", fv_cnt - base, locked, last_fv, exp_fields(10, 20, 30, 1, 1'b0, 1'b0));
    end
  endtask

`ifdef LTC_PARITY_EN
  task automatic test_parity();
    logic [79:0] fr;
    int base, pbase;
    apply_reset();
    base  = fv_cnt;
    pbase = pe_cnt;
    send_frame(build_frame(5, 6, 7, 8, 1'b0, 1'b0), HALF_25);
    send_frame(build_frame(5, 6, 7, 9, 1'b0, 1'b0), HALF_25);
    fr = build_frame(5, 6, 7, 10, 1'b0, 1'b0);
    fr[59] = ~fr[59];
    send_frame(fr, HALF_25);
    flush();
    asserts++;
    if (pe_cnt - pbase != 1 || fv_cnt - base != 1) begin
      failures++; $display("FAIL parity_strobes: got pe %0d fv %0d expected 1 1", pe_cnt - pbase, fv_cnt - base);
    end
    asserts++;
    if (locked !== 1'b1 || cur_fields() !== exp_fields(5, 6, 7, 9, 1'b0, 1'b0)) begin
      failures++; $display("FAIL parity_hold: got %b/%h expected 1/%h", locked, cur_fields(), exp_fields(5, 6, 7, 9, 1'b0, 1'b0));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_25fps();
    test_reset_abort();
    test_24fps();
    test_back_to_back();
    test_glitch();
    test_timeout();
    test_bit_slip();
`ifdef LTC_PARITY_EN
    test_parity();
`else
    asserts++;
    if (pe_cnt != 0) begin
      failures++; $display("FAIL parity_tied: got %0d strobes expected 0", pe_cnt);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
